decode_stage: RTL and testbench

// - Registered, parametrised decode stage between fetch and execute; successor to the combinational decoder.
// - Buffers fetched instructions in a DEPTH-entry queue and decodes the head entry.
// - Issues the decoded bundle to execute over a valid/ready handshake.
// - A register scoreboard stalls issue on read-after-write hazards against in-flight loads and PCR reads.

---
 rtl/decode_stage.sv | 204 ++++++++++++++++++++
 tb/tb_decode_stage.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// decode_stage: registered decode stage between fetch and execute.
// A DEPTH-entry queue buffers fetched instructions, and the head entry is decoded.
// The decoded bundle is issued over a valid/ready handshake.
// Optional feature macro: DECODE_SCOREBOARD_EN. When it is defined, a register
// scoreboard stalls issue on RAW hazards against in-flight LOAD and PCR results.
// Encodings: opcode is inst[6:0], wd=inst[31:27], rs1=inst[26:22],
// rs2=inst[21:17], pcr_cmd=inst[8:7].

module decode_stage #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned PC_W  = 32,
  parameter int unsigned NREGS = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [PC_W-1:0]  in_pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PC_W-1:0]  out_pc,
  output logic [31:0]      out_inst,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [4:0]       out_wd,
  output logic [2:0]       out_wb_sel,
  output logic             out_rf_wr_en,
  output logic             out_mem_req,
  output logic             out_mem_type,
  output logic             out_pcr_en,
  output logic [1:0]       out_pcr_cmd,
  input  logic             wb_valid,
  input  logic [4:0]       wb_rd,
  output logic [NREGS-1:0] busy
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [6:0] {
    OPC_LOAD   = 7'h03,
    OPC_OP_IMM = 7'h13,
    OPC_STORE  = 7'h23,
    OPC_OP     = 7'h33,
    OPC_LUI    = 7'h37,
    OPC_BRANCH = 7'h63,
    OPC_JALR   = 7'h67,
    OPC_JAL    = 7'h6F,
    OPC_PCR    = 7'h73
  } opcode_e;

  typedef enum logic [2:0] {
    WB_NONE = 3'd0,
    WB_ALU  = 3'd1,
    WB_MEM  = 3'd2,
    WB_PC4  = 3'd3,
    WB_PCR  = 3'd4
  } wb_sel_e;

  typedef enum logic {
    MEM_REQ_READ  = 1'b0,
    MEM_REQ_WRITE = 1'b1
  } mem_type_e;

  logic [31:0]      inst_q [DEPTH];
  logic [PC_W-1:0]  pc_q   [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic        empty, hazard, push, pop;
  logic [31:0] head_inst;
  logic [6:0]  opc;
  logic        chk_rs1, chk_rs2, sb_set;

  assign empty     = (count_q == '0);
  assign in_ready  = (count_q != CNT_W'(DEPTH));
  assign out_valid = !empty && !hazard;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign head_inst = inst_q[rd_ptr_q];
  assign opc       = head_inst[6:0];
  assign out_inst  = head_inst;
  assign out_pc    = pc_q[rd_ptr_q];
  assign out_rs1   = head_inst[26:22];
  assign out_rs2   = head_inst[21:17];

  // Queue pointer/count next state; flush wins over a same-cycle push or pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (!push && pop) count_d = count_q - 1'b1;
    end
  end

  // Queue control registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; cleared on reset so the decode outputs read as zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        inst_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else if (push && !flush) begin
      inst_q[wr_ptr_q] <= in_inst;
      pc_q[wr_ptr_q]   <= in_pc;
    end
  end

  // Head decode, plus which sources need a hazard check.
  always_comb begin
    out_wd       = head_inst[31:27];
    out_wb_sel   = WB_NONE;
    out_rf_wr_en = 1'b0;
    out_mem_req  = 1'b0;
    out_mem_type = MEM_REQ_READ;
    out_pcr_en   = 1'b0;
    out_pcr_cmd  = 2'b00;
    chk_rs1      = 1'b1;
    chk_rs2      = 1'b0;
    sb_set       = 1'b0;
    case (opc)
      OPC_OP: begin
        out_wb_sel = WB_ALU; out_rf_wr_en = 1'b1; chk_rs2 = 1'b1;
      end
      OPC_OP_IMM: begin
        out_wb_sel = WB_ALU; out_rf_wr_en = 1'b1;
      end
      OPC_LUI: begin
        out_wb_sel = WB_ALU; out_rf_wr_en = 1'b1; chk_rs1 = 1'b0;
      end
      OPC_LOAD: begin
        out_wb_sel = WB_MEM; out_rf_wr_en = 1'b1; out_mem_req = 1'b1; sb_set = 1'b1;
      end
      OPC_STORE: begin
        out_mem_req = 1'b1; out_mem_type = MEM_REQ_WRITE; chk_rs2 = 1'b1;
      end
      OPC_BRANCH: chk_rs2 = 1'b1;
      OPC_JAL: begin
        out_wb_sel = WB_PC4; out_rf_wr_en = 1'b1; chk_rs1 = 1'b0; out_wd = 5'd1;
      end
      OPC_JALR: begin
        out_wb_sel = WB_PC4; out_rf_wr_en = 1'b1;
      end
      OPC_PCR: begin
        out_wb_sel = WB_PCR; out_rf_wr_en = 1'b1; out_pcr_en = 1'b1;
        out_pcr_cmd = head_inst[8:7]; sb_set = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef DECODE_SCOREBOARD_EN
  logic [NREGS-1:0] busy_q, busy_d;

  // Scoreboard update: a clear is applied first so a same-register set wins.
  // A pop that coincides with a flush is discarded and sets nothing.
  always_comb begin
    busy_d = busy_q;
    if (wb_valid) busy_d[wb_rd] = 1'b0;
    if (pop && !flush && sb_set && (out_wd != 5'd0)) busy_d[out_wd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Scoreboard register; flush leaves it intact for older in-flight writebacks.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  assign hazard = (chk_rs1 && busy_q[out_rs1]) || (chk_rs2 && busy_q[out_rs2]);
  assign busy   = busy_q;
`else
  logic unused_sb;
  assign unused_sb = ^{wb_valid, wb_rd, sb_set, chk_rs1, chk_rs2};
  assign hazard    = 1'b0;
  assign busy      = '0;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed scenarios followed by random traffic.
// Every output is compared each cycle against a queue/array reference model.

module tb_decode_stage;

  localparam int unsigned DEPTH = 2;
`ifdef DECODE_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif

  localparam logic [6:0] T_LOAD = 7'h03, T_OPIMM = 7'h13, T_STORE = 7'h23, T_OP = 7'h33,
                         T_LUI = 7'h37, T_BRANCH = 7'h63, T_JALR = 7'h67, T_JAL = 7'h6F,
                         T_PCR = 7'h73;

  logic        clk, reset;
  logic        in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] in_inst, in_pc, out_pc, out_inst;
  logic [4:0]  out_rs1, out_rs2, out_wd, wb_rd;
  logic [2:0]  out_wb_sel;
  logic        out_rf_wr_en, out_mem_req, out_mem_type, out_pcr_en, wb_valid;
  logic [1:0]  out_pcr_cmd;
  logic [31:0] busy;

  decode_stage #(.DEPTH(DEPTH), .PC_W(32), .NREGS(32)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_wd(out_wd), .out_wb_sel(out_wb_sel),
    .out_rf_wr_en(out_rf_wr_en), .out_mem_req(out_mem_req), .out_mem_type(out_mem_type),
    .out_pcr_en(out_pcr_en), .out_pcr_cmd(out_pcr_cmd),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
  } ent_t;

  typedef struct {
    logic [6:0] op;
    logic [4:0] rs1, rs2, wd;
    logic [2:0] wb;
    bit         wr, mreq, mtype, pcr_en, chk1, chk2;
    logic [1:0] cmd;
  } dec_t;

  ent_t        q[$];
  logic [31:0] busy_m;
  bit          storage_zero;
  int          checks, failures;

  function automatic logic [31:0] mk(logic [6:0] op, logic [4:0] rd, logic [4:0] s1,
                                     logic [4:0] s2, logic [1:0] cmd);
    return {rd, s1, s2, 8'h00, cmd, op};
  endfunction

  // Reference decode written directly from the opcode rules.
  function automatic dec_t decode(logic [31:0] inst);
    dec_t d;
    d.op     = inst[6:0];
    d.rs1    = inst[26:22];
    d.rs2    = inst[21:17];
    d.wd     = (d.op == T_JAL) ? 5'd1 : inst[31:27];
    d.wr     = d.op inside {T_OP, T_OPIMM, T_LUI, T_LOAD, T_JAL, T_JALR, T_PCR};
    d.wb     = (d.op inside {T_OP, T_OPIMM, T_LUI}) ? 3'd1 :
               (d.op == T_LOAD) ? 3'd2 :
               (d.op inside {T_JAL, T_JALR}) ? 3'd3 :
               (d.op == T_PCR) ? 3'd4 : 3'd0;
    d.mreq   = d.op inside {T_LOAD, T_STORE};
    d.mtype  = (d.op == T_STORE);
    d.pcr_en = (d.op == T_PCR);
    d.cmd    = d.pcr_en ? inst[8:7] : 2'b00;
    d.chk1   = !(d.op inside {T_LUI, T_JAL});
    d.chk2   = d.op inside {T_OP, T_STORE, T_BRANCH};
    return d;
  endfunction

  function automatic bit hazard_m();
    dec_t d;
    if (q.size() == 0) return 1'b0;
    d = decode(q[0].inst);
    return SB && ((d.chk1 && d.rs1 != 0 && busy_m[d.rs1]) ||
                  (d.chk2 && d.rs2 != 0 && busy_m[d.rs2]));
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    ent_t h;
    dec_t d;
    bit   ne;
    ne = (q.size() != 0);
    chk("in_ready", in_ready, q.size() != DEPTH);
    chk("out_valid", out_valid, ne && !hazard_m());
    chk("busy", busy, SB ? busy_m : 32'd0);
    if (ne || storage_zero) begin
      if (ne) h = q[0];
      else begin
        h.inst = '0;
        h.pc   = '0;
      end
      d = decode(h.inst);
      chk("out_pc", out_pc, h.pc);
      chk("out_inst", out_inst, h.inst);
      chk("out_rs1", out_rs1, d.rs1);
      chk("out_rs2", out_rs2, d.rs2);
      chk("out_wd", out_wd, d.wd);
      chk("out_wb_sel", out_wb_sel, d.wb);
      chk("out_rf_wr_en", out_rf_wr_en, d.wr);
      chk("out_mem_req", out_mem_req, d.mreq);
      chk("out_mem_type", out_mem_type, d.mtype);
      chk("out_pcr_en", out_pcr_en, d.pcr_en);
      chk("out_pcr_cmd", out_pcr_cmd, d.cmd);
    end
  endtask

  // One clock: drive inputs, check at the falling edge, advance the model at the rising edge.
  task automatic cycle(input bit iv, input logic [31:0] inst, input logic [31:0] pc,
                       input bit ordy, input bit fl, input bit wbv, input logic [4:0] wbrd);
    bit   push, pop, sset;
    dec_t d;
    ent_t e;
    in_valid  = iv;
    in_inst   = inst;
    in_pc     = pc;
    out_ready = ordy;
    flush     = fl;
    wb_valid  = wbv;
    wb_rd     = wbrd;
    @(negedge clk);
    check_outputs();
    push = iv && (q.size() != DEPTH);
    pop  = ordy && (q.size() != 0) && !hazard_m();
    sset = 1'b0;
    if (pop && !fl) begin
      d    = decode(q[0].inst);
      sset = (d.op inside {T_LOAD, T_PCR}) && (d.wd != 0);
    end
    @(posedge clk);
    if (wbv) busy_m[wbrd] = 1'b0;
    if (sset) busy_m[d.wd] = 1'b1;
    if (fl) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (push) begin
        e.inst = inst;
        e.pc   = pc;
        q.push_back(e);
        storage_zero = 1'b0;
      end
    end
    #1;
  endtask

  // Asynchronous reset asserted between clock edges, checked before any edge arrives.
  task automatic do_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
    wb_valid  = 1'b0;
    wb_rd     = '0;
    in_inst   = '0;
    in_pc     = '0;
    q.delete();
    busy_m       = '0;
    storage_zero = 1'b1;
    #2;
    check_outputs();
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_ready", in_ready, 1'b1);
    chk("rst_busy", busy, 32'd0);
    chk("rst_wb_sel", out_wb_sel, 3'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  function automatic logic [31:0] rnd_inst();
    logic [6:0] ops [10];
    logic [4:0] rd, s1, s2;
    logic [7:0] mid;
    logic [1:0] cmd;
    ops = '{T_LOAD, T_OPIMM, T_STORE, T_OP, T_LUI, T_BRANCH, T_JALR, T_JAL, T_PCR, 7'h7F};
    rd  = 5'($urandom_range(0, 7));
    s1  = 5'($urandom_range(0, 7));
    s2  = 5'($urandom_range(0, 7));
    mid = 8'($urandom_range(0, 255));
    cmd = 2'($urandom_range(0, 3));
    return {rd, s1, s2, mid, cmd, ops[$urandom_range(0, 9)]};
  endfunction

  initial begin
    checks   = 0;
    failures = 0;
    do_reset();
    cycle(0, '0, '0, 0, 0, 0, '0);

    // ADD x3,x1,x2 is visible the cycle after it is accepted.
    cycle(1, mk(T_OP, 3, 1, 2, 0), 32'h100, 1, 0, 0, '0);
    chk("add_valid", out_valid, 1'b1);
    chk("add_wb_sel", out_wb_sel, 3'd1);
    chk("add_wr_en", out_rf_wr_en, 1'b1);
    chk("add_wd", out_wd, 5'd3);
    chk("add_rs1", out_rs1, 5'd1);
    chk("add_rs2", out_rs2, 5'd2);
    cycle(0, '0, '0, 1, 0, 0, '0);

    // Fill with out_ready low; a full queue refuses input even while popping.
    for (int i = 0; i < DEPTH; i++)
      cycle(1, mk(T_OP, 5'(10 + i), 1, 2, 0), 32'h200 + 32'(4 * i), 0, 0, 0, '0);
    chk("full_ready", in_ready, 1'b0);
    cycle(1, mk(T_OPIMM, 30, 1, 0, 0), 32'h2F0, 0, 0, 0, '0);
    chk("full_head_stable", out_pc, 32'h200);
    cycle(1, mk(T_OPIMM, 30, 1, 0, 0), 32'h2F4, 1, 0, 0, '0);
    chk("full_pop_no_push", out_pc, 32'h204);
    chk("full_pop_ready", in_ready, 1'b1);
    for (int i = 0; i < DEPTH; i++) cycle(0, '0, '0, 1, 0, 0, '0);
    chk("drained_valid", out_valid, 1'b0);

    // LOAD x5 then ADD x6,x5,x0.
    cycle(1, mk(T_LOAD, 5, 1, 0, 0), 32'h300, 1, 0, 0, '0);
    cycle(1, mk(T_OP, 6, 5, 0, 0), 32'h304, 1, 0, 0, '0);
    chk("raw_stall", out_valid, !SB);
    chk("raw_busy5", busy[5], SB);
    cycle(0, '0, '0, 0, 0, 1, 5'd5);
    chk("raw_release", out_valid, 1'b1);
    chk("raw_busy5_clr", busy[5], 1'b0);
    cycle(0, '0, '0, 1, 0, 0, '0);

    // Set and clear of x7 in the same cycle: set wins.
    cycle(1, mk(T_LOAD, 7, 0, 0, 0), 32'h400, 0, 0, 0, '0);
    cycle(0, '0, '0, 1, 0, 1, 5'd7);
    chk("set_wins", busy[7], SB);

    // Flush a full queue while in_valid is high.
    for (int i = 0; i < DEPTH; i++)
      cycle(1, mk(T_OP, 12, 1, 2, 0), 32'h500 + 32'(4 * i), 0, 0, 0, '0);
    cycle(1, mk(T_OP, 13, 1, 2, 0), 32'h5F0, 0, 1, 0, '0);
    chk("flush_valid", out_valid, 1'b0);
    chk("flush_ready", in_ready, 1'b1);
    chk("flush_busy7", busy[7], SB);
    cycle(0, '0, '0, 0, 0, 0, '0);
    chk("flush_not_stored", out_valid, 1'b0);

    // JAL, PCR and STORE decode.
    cycle(1, mk(T_JAL, 20, 3, 4, 0), 32'h600, 0, 0, 0, '0);
    chk("jal_wd", out_wd, 5'd1);
    chk("jal_wb_sel", out_wb_sel, 3'd3);
    cycle(1, mk(T_PCR, 9, 1, 0, 2'b10), 32'h604, 1, 0, 0, '0);
    chk("pcr_en", out_pcr_en, 1'b1);
    chk("pcr_cmd", out_pcr_cmd, 2'b10);
    cycle(1, mk(T_STORE, 0, 1, 2, 0), 32'h608, 1, 0, 0, '0);
    chk("st_mem_req", out_mem_req, 1'b1);
    chk("st_mem_type", out_mem_type, 1'b1);
    chk("st_wr_en", out_rf_wr_en, 1'b0);
    chk("pcr_busy9", busy[9], SB);

    // Reset mid-stream.
    cycle(1, mk(T_OP, 4, 1, 2, 0), 32'h700, 0, 0, 0, '0);
    do_reset();
    cycle(0, '0, '0, 0, 0, 0, '0);

    // Random traffic against the reference model.
    for (int i = 0; i < 1500; i++) begin
      cycle(bit'($urandom_range(0, 1)), rnd_inst(), $urandom,
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 31) == 0),
            ($urandom_range(0, 3) == 0), 5'($urandom_range(0, 7)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
